// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared constants and types for the pipeline stall/flush scheduler.
//   - REG_ID_W       : architectural register index width
//   - mem_state_e    : data-memory wait FSM states
//   - W_* / K_*      : bit positions inside the wen / kill control vectors
//   - WEN_* / KILL_* : control vectors for each scheduling decision
package pipe_ctrl_pkg;

    localparam int REG_ID_W = 5;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_ERR  = 2'd2
    } mem_state_e;

    // wen vector: {pc, IF_ID, ID_EX, EX_MEM, MEM_WB}
    localparam int W_PC     = 4;
    localparam int W_IF_ID  = 3;
    localparam int W_ID_EX  = 2;
    localparam int W_EX_MEM = 1;
    localparam int W_MEM_WB = 0;

    // kill vector: {ID, EX, MEM, WB}
    localparam int K_ID  = 3;
    localparam int K_EX  = 2;
    localparam int K_MEM = 1;
    localparam int K_WB  = 0;

    localparam logic [4:0] WEN_RUN       = 5'b11111;
    localparam logic [4:0] WEN_MEM_STALL = 5'b00001;
    localparam logic [4:0] WEN_MDU_STALL = 5'b00011;
    localparam logic [4:0] WEN_LU_STALL  = 5'b00111;

    localparam logic [3:0] KILL_NONE      = 4'b0000;
    localparam logic [3:0] KILL_MEM_STALL = 4'b0001;
    localparam logic [3:0] KILL_MDU_STALL = 4'b0010;
    localparam logic [3:0] KILL_REDIRECT  = 4'b1100;
    localparam logic [3:0] KILL_LU        = 4'b0100;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Bundle between the pipeline datapath and the stall/flush scheduler.
//   master : datapath side, drives hazard sources, receives wen/kill/status
//   slave  : scheduler side (pipe_ctrl)
//   Hazard sources : rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, load_EX,
//                    redirect_EX, mdu_op_EX, mem_req_MEM, mem_ack
//   Controls       : pc_wen, wen_IF_ID, wen_ID_EX, wen_EX_MEM, wen_MEM_WB,
//                    kill_ID, kill_EX, kill_MEM, kill_WB
//   Status         : mdu_done, mem_err, stall_cnt[CNT_W]
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [REG_ID_W-1:0] rs1_ID;
    logic [REG_ID_W-1:0] rs2_ID;
    logic                rs1_used_ID;
    logic                rs2_used_ID;
    logic [REG_ID_W-1:0] rd_EX;
    logic                load_EX;
    logic                redirect_EX;
    logic                mdu_op_EX;
    logic                mem_req_MEM;
    logic                mem_ack;

    logic                pc_wen;
    logic                wen_IF_ID;
    logic                wen_ID_EX;
    logic                wen_EX_MEM;
    logic                wen_MEM_WB;
    logic                kill_ID;
    logic                kill_EX;
    logic                kill_MEM;
    logic                kill_WB;
    logic                mdu_done;
    logic                mem_err;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, load_EX,
               redirect_EX, mdu_op_EX, mem_req_MEM, mem_ack,
        input  pc_wen, wen_IF_ID, wen_ID_EX, wen_EX_MEM, wen_MEM_WB,
               kill_ID, kill_EX, kill_MEM, kill_WB, mdu_done, mem_err, stall_cnt
    );

    modport slave (
        input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, load_EX,
               redirect_EX, mdu_op_EX, mem_req_MEM, mem_ack,
        output pc_wen, wen_IF_ID, wen_ID_EX, wen_EX_MEM, wen_MEM_WB,
               kill_ID, kill_EX, kill_MEM, kill_WB, mdu_done, mem_err, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_mdu_timer.sv
// pipe_ctrl_mdu_timer
//   Residency timer for a multi-cycle MUL/DIV op sitting in EX.
//   Counts MDU_LAT-1 down to 1; the op's result is valid while the count is 1.
//   clk        in  clock
//   rst        in  asynchronous active-high reset (count cleared)
//   mdu_op_i   in  valid MUL/DIV op in EX
//   s_mem_i    in  memory stall active (EX cannot advance)
//   mdu_done_o out MDU result valid in EX this cycle
module pipe_ctrl_mdu_timer #(
    parameter int MDU_LAT = 34
) (
    input  logic clk,
    input  logic rst,
    input  logic mdu_op_i,
    input  logic s_mem_i,
    output logic mdu_done_o
);
    localparam int CW = $clog2(MDU_LAT);
    localparam logic [CW-1:0] C_LOAD = CW'(MDU_LAT - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The countdown keeps running under a memory stall; only the final
    // "done" count waits for the stall to clear so the result is consumed.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == '0) begin
            if (mdu_op_i && !s_mem_i) begin
                cnt_d = C_LOAD;
            end
        end else if (cnt_q != C_ONE) begin
            cnt_d = cnt_q - C_ONE;
        end else if (!s_mem_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mdu_done_o = (cnt_q == C_ONE);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Stall/flush scheduler for the 5-stage pipeline. Produces write enables and
//   bubble kills for PC, IF_ID, ID_EX, EX_MEM, MEM_WB from load-use hazards,
//   EX redirects, multi-cycle MDU ops and data-memory wait states (with
//   timeout). Counts stalled cycles (pc_wen=0) in a saturating counter.
//   clk  in  clock
//   rst  in  asynchronous active-high reset; forces wen=0, kill=1
//   bus  pipe_ctrl_if.slave (hazard sources in, controls/status out)
//
//   Mem wait FSM
//   state  | meaning
//   M_IDLE | no outstanding stalled access
//   M_WAIT | access stalled, counting wait cycles up to MEM_TIMEOUT
//   M_ERR  | timeout: one-cycle release, faulting op retired as a bubble
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT     = 34,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] W_ONE   = WW'(1);
    localparam logic [WW-1:0] W_LIMIT = WW'(MEM_TIMEOUT);

    mem_state_e       state_q, state_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       s_mem, s_mdu, s_lu, mdu_done;
    logic [4:0] wen;
    logic [3:0] kill;

    assign s_mem = bus.mem_req_MEM & ~bus.mem_ack & (state_q != M_ERR);
    assign s_mdu = bus.mdu_op_EX & ~mdu_done;
    assign s_lu  = bus.load_EX & (bus.rd_EX != '0)
                 & ((bus.rs1_used_ID & (bus.rs1_ID == bus.rd_EX))
                  | (bus.rs2_used_ID & (bus.rs2_ID == bus.rd_EX)));

    pipe_ctrl_mdu_timer #(
        .MDU_LAT(MDU_LAT)
    ) u_mdu_timer (
        .clk        (clk),
        .rst        (rst),
        .mdu_op_i   (bus.mdu_op_EX),
        .s_mem_i    (s_mem),
        .mdu_done_o (mdu_done)
    );

    // Redirect sits below the EX-holding stalls so it is only taken when EX
    // actually advances; it outranks load-use because ID gets squashed.
    always_comb begin
        wen  = WEN_RUN;
        kill = KILL_NONE;
        if (s_mem) begin
            wen  = WEN_MEM_STALL;
            kill = KILL_MEM_STALL;
        end else if (s_mdu) begin
            wen  = WEN_MDU_STALL;
            kill = KILL_MDU_STALL;
        end else if (bus.redirect_EX) begin
            kill = KILL_REDIRECT;
        end else if (s_lu) begin
            wen  = WEN_LU_STALL;
            kill = KILL_LU;
        end
        if (state_q == M_ERR) begin
            kill[K_WB] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            M_IDLE: begin
                if (s_mem) begin
                    state_d = M_WAIT;
                    wcnt_d  = W_ONE;
                end
            end
            M_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = M_IDLE;
                end else if (wcnt_q == W_LIMIT) begin
                    state_d = M_ERR;
                end else begin
                    wcnt_d = wcnt_q + W_ONE;
                end
            end
            M_ERR:   state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!wen[W_PC] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= M_IDLE;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset overrides the combinational controls immediately, not at the edge.
    assign bus.pc_wen     = ~rst & wen[W_PC];
    assign bus.wen_IF_ID  = ~rst & wen[W_IF_ID];
    assign bus.wen_ID_EX  = ~rst & wen[W_ID_EX];
    assign bus.wen_EX_MEM = ~rst & wen[W_EX_MEM];
    assign bus.wen_MEM_WB = ~rst & wen[W_MEM_WB];
    assign bus.kill_ID    = rst | kill[K_ID];
    assign bus.kill_EX    = rst | kill[K_EX];
    assign bus.kill_MEM   = rst | kill[K_MEM];
    assign bus.kill_WB    = rst | kill[K_WB];
    assign bus.mdu_done   = ~rst & mdu_done;
    assign bus.mem_err    = ~rst & (state_q == M_ERR);
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    localparam int MDU_LAT     = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(
        .MDU_LAT     (MDU_LAT),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // reference model state: timestamps / run lengths, not register images
    int cyc, mb_t0, mw_n, st_n;
    bit mb_busy, me_now, sm;
    bit e_pc, e_if, e_ide, e_exm, e_mwb;
    bit k_id, k_ex, k_mem, k_wb, e_done, e_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        cyc = 0; mb_t0 = 0; mw_n = 0; st_n = 0;
        mb_busy = 1'b0; me_now = 1'b0;
    endfunction

    function automatic void eval_model();
        bit smdu, slu;
        if (rst) begin
            {e_pc, e_if, e_ide, e_exm, e_mwb} = 5'b00000;
            {k_id, k_ex, k_mem, k_wb} = 4'b1111;
            e_done = 1'b0; e_err = 1'b0; sm = 1'b0;
            return;
        end
        e_err  = me_now;
        sm     = bus.mem_req_MEM && !bus.mem_ack && !me_now;
        e_done = mb_busy && ((cyc - mb_t0) >= MDU_LAT - 1);
        smdu   = bus.mdu_op_EX && !e_done;
        slu    = bus.load_EX && (bus.rd_EX != 0) &&
                 ((bus.rs1_used_ID && bus.rs1_ID == bus.rd_EX) ||
                  (bus.rs2_used_ID && bus.rs2_ID == bus.rd_EX));
        {e_pc, e_if, e_ide, e_exm, e_mwb} = 5'b11111;
        {k_id, k_ex, k_mem, k_wb} = 4'b0000;
        if (sm) begin
            {e_pc, e_if, e_ide, e_exm} = 4'b0000;
            k_wb = 1'b1;
        end else if (smdu) begin
            {e_pc, e_if, e_ide} = 3'b000;
            k_mem = 1'b1;
        end else if (bus.redirect_EX) begin
            k_id = 1'b1; k_ex = 1'b1;
        end else if (slu) begin
            {e_pc, e_if} = 2'b00;
            k_ex = 1'b1;
        end
        if (me_now) k_wb = 1'b1;
    endfunction

    function automatic void advance_model();
        if (!e_pc && st_n < CNT_MAX) st_n++;
        if (mb_busy) begin
            if (e_done && !sm) mb_busy = 1'b0;
        end else if (bus.mdu_op_EX && !sm) begin
            mb_busy = 1'b1;
            mb_t0   = cyc;
        end
        if (me_now) begin
            me_now = 1'b0;
        end else if (sm) begin
            mw_n++;
            if (mw_n == MEM_TIMEOUT + 1) begin
                me_now = 1'b1;
                mw_n   = 0;
            end
        end else begin
            mw_n = 0;
        end
        cyc++;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc_wen",     bus.pc_wen,     e_pc);
            chk("wen_IF_ID",  bus.wen_IF_ID,  e_if);
            chk("wen_ID_EX",  bus.wen_ID_EX,  e_ide);
            chk("wen_EX_MEM", bus.wen_EX_MEM, e_exm);
            chk("wen_MEM_WB", bus.wen_MEM_WB, e_mwb);
            chk("kill_ID",    bus.kill_ID,    k_id);
            chk("kill_EX",    bus.kill_EX,    k_ex);
            chk("kill_MEM",   bus.kill_MEM,   k_mem);
            chk("kill_WB",    bus.kill_WB,    k_wb);
            chk("mdu_done",   bus.mdu_done,   e_done);
            chk("mem_err",    bus.mem_err,    e_err);
            chk("stall_cnt",  bus.stall_cnt,  st_n);
        end
    end

    task automatic idle_in();
        bus.rs1_ID = '0; bus.rs2_ID = '0; bus.rs1_used_ID = 1'b0; bus.rs2_used_ID = 1'b0;
        bus.rd_EX = '0; bus.load_EX = 1'b0; bus.redirect_EX = 1'b0; bus.mdu_op_EX = 1'b0;
        bus.mem_req_MEM = 1'b0; bus.mem_ack = 1'b0;
    endtask

    task automatic look();
        eval_model();
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) model_reset(); else advance_model();
        #1;
    endtask

    // Stage contents only change when the stage register is written;
    // a killed write turns the stage into a bubble.
    task automatic rand_inputs();
        int k;
        if (e_ide) begin
            if (k_ex) begin
                bus.load_EX = 1'b0; bus.mdu_op_EX = 1'b0; bus.redirect_EX = 1'b0; bus.rd_EX = '0;
            end else begin
                k = $urandom_range(0, 9);
                bus.load_EX     = (k < 3);
                bus.mdu_op_EX   = (k == 3 || k == 4);
                bus.redirect_EX = (k == 5);
                bus.rd_EX       = 5'($urandom_range(0, 3));
            end
        end
        if (e_if) begin
            if (k_id) begin
                bus.rs1_used_ID = 1'b0; bus.rs2_used_ID = 1'b0;
            end else begin
                bus.rs1_ID      = 5'($urandom_range(0, 3));
                bus.rs2_ID      = 5'($urandom_range(0, 3));
                bus.rs1_used_ID = 1'($urandom_range(0, 1));
                bus.rs2_used_ID = 1'($urandom_range(0, 1));
            end
        end
        if (e_exm) begin
            bus.mem_req_MEM = k_mem ? 1'b0 : ($urandom_range(0, 2) == 0);
        end
        bus.mem_ack = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        idle_in();
        model_reset();
        eval_model();
        chk_on = 1'b1;

        // reset state
        look();
        chk("rst_wen", {bus.pc_wen, bus.wen_IF_ID, bus.wen_ID_EX, bus.wen_EX_MEM, bus.wen_MEM_WB}, 5'b00000);
        chk("rst_kill", {bus.kill_ID, bus.kill_EX, bus.kill_MEM, bus.kill_WB}, 4'b1111);
        chk("rst_cnt", bus.stall_cnt, 0);
        adv();
        look();
        rst = 1'b0;
        eval_model();
        adv();

        // load-use on rs2
        bus.load_EX = 1'b1; bus.rd_EX = 5'd5; bus.rs2_ID = 5'd5; bus.rs2_used_ID = 1'b1;
        look();
        chk("lu_pc", bus.pc_wen, 0);
        chk("lu_ifid", bus.wen_IF_ID, 0);
        chk("lu_kill_ex", bus.kill_EX, 1);
        chk("lu_idex", bus.wen_ID_EX, 1);
        adv();
        bus.load_EX = 1'b0; bus.rd_EX = '0;
        look();
        chk("lu_after", {bus.pc_wen, bus.wen_IF_ID, bus.wen_ID_EX, bus.wen_EX_MEM, bus.wen_MEM_WB}, 5'b11111);
        adv();
        bus.load_EX = 1'b1; bus.rd_EX = '0; bus.rs2_ID = '0;
        look();
        chk("lu_x0", bus.pc_wen, 1);
        adv();

        // redirect beats load-use
        idle_in();
        bus.load_EX = 1'b1; bus.rd_EX = 5'd5; bus.rs1_ID = 5'd5; bus.rs1_used_ID = 1'b1;
        bus.redirect_EX = 1'b1;
        look();
        chk("redir_wen", {bus.pc_wen, bus.wen_IF_ID, bus.wen_ID_EX}, 3'b111);
        chk("redir_kill", {bus.kill_ID, bus.kill_EX}, 2'b11);
        adv();
        idle_in();
        look();
        chk("redir_cnt", bus.stall_cnt, 1);
        adv();

        // MDU held in EX
        bus.mdu_op_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("mdu_stall_idex", bus.wen_ID_EX, 0);
            chk("mdu_stall_kmem", bus.kill_MEM, 1);
            adv();
        end
        look();
        chk("mdu_done", bus.mdu_done, 1);
        chk("mdu_release", {bus.pc_wen, bus.wen_ID_EX, bus.wen_EX_MEM}, 3'b111);
        adv();
        idle_in();

        // mem wait released by ack
        bus.mem_req_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("mem_wait_exmem", bus.wen_EX_MEM, 0);
            chk("mem_wait_kwb", bus.kill_WB, 1);
            adv();
        end
        bus.mem_ack = 1'b1;
        look();
        chk("mem_ack_exmem", bus.wen_EX_MEM, 1);
        adv();
        idle_in();
        look();
        chk("mem_ack_cnt", bus.stall_cnt, 7);
        adv();

        // mem timeout
        bus.mem_req_MEM = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
            look();
            chk("to_stall", {bus.pc_wen, bus.mem_err}, 2'b00);
            adv();
        end
        look();
        chk("to_err", {bus.mem_err, bus.kill_WB, bus.pc_wen, bus.wen_EX_MEM}, 4'b1111);
        adv();
        bus.mem_req_MEM = 1'b0;
        look();
        chk("to_after", bus.mem_err, 0);
        chk("to_cnt", bus.stall_cnt, 12);
        adv();

        // MDU overlapping a mem stall
        bus.mdu_op_EX = 1'b1;
        look(); adv();
        bus.mem_req_MEM = 1'b1;
        look(); adv();
        look(); adv();
        look();
        chk("ovl_done_hold", {bus.mdu_done, bus.wen_ID_EX}, 2'b10);
        adv();
        look();
        chk("ovl_done_hold2", bus.mdu_done, 1);
        adv();
        bus.mem_ack = 1'b1;
        look();
        chk("ovl_release", {bus.mdu_done, bus.pc_wen, bus.wen_ID_EX}, 3'b111);
        adv();
        idle_in();
        look();
        chk("ovl_cnt", bus.stall_cnt, 17);
        adv();

        // async reset mid MDU count and mid mem wait
        bus.mdu_op_EX = 1'b1;
        look(); adv();
        bus.mem_req_MEM = 1'b1;
        look(); adv();
        look();
        rst = 1'b1;
        model_reset();
        eval_model();
        #1;
        chk("arst_wen", {bus.pc_wen, bus.wen_ID_EX, bus.wen_EX_MEM}, 3'b000);
        chk("arst_kill", {bus.kill_ID, bus.kill_WB}, 2'b11);
        chk("arst_stat", {bus.mdu_done, bus.mem_err}, 2'b00);
        chk("arst_cnt", bus.stall_cnt, 0);
        adv();
        idle_in();
        look();
        rst = 1'b0;
        eval_model();
        adv();
        bus.mdu_op_EX = 1'b1;
        look();
        chk("restart_cnt", bus.stall_cnt, 0);
        chk("restart_stall", bus.wen_ID_EX, 0);
        adv();
        look(); adv();
        look(); adv();
        look();
        chk("restart_done", bus.mdu_done, 1);
        adv();
        idle_in();

        // counter saturation
        bus.load_EX = 1'b1; bus.rd_EX = 5'd5; bus.rs1_ID = 5'd5; bus.rs1_used_ID = 1'b1;
        for (int i = 0; i < 260; i++) begin
            eval_model();
            adv();
        end
        look();
        chk("sat_cnt", bus.stall_cnt, CNT_MAX);
        adv();
        idle_in();
        eval_model();
        adv();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            eval_model();
            adv();
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
